riscv_mem_arbiter: RTL and testbench

Arbiter sharing one single-port 32-bit memory between the RV32I pipeline's instruction-fetch (IF) port and data-access (MEM stage) port. Each requester holds a request until a one-cycle acknowledge with read data. The arbiter sequences each access through a small FSM and exports per-port stall signals for the hazard/pipeline control logic. Fixed data-over-fetch priority, with an optional fetch-starvation guard.

---
 rtl/riscv_mem_arbiter_pkg.sv | 29 ++
 rtl/riscv_arb_starve_ctr.sv | 28 ++
 rtl/riscv_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types for the RV32I instruction-fetch / data-access memory arbiter.
package riscv_mem_arbiter_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] xlen_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} arb_owner_e;

  typedef struct packed {
    logic       we;
    xlen_t      addr;
    xlen_t      wdata;
    logic [3:0] be;
  } mem_req_t;

  // A fetch is always a full-word read.
  function automatic mem_req_t fetch_req(input xlen_t addr);
    mem_req_t r;
    r.we    = 1'b0;
    r.addr  = addr;
    r.wdata = '0;
    r.be    = 4'hF;
    return r;
  endfunction

endpackage

// File: rtl/riscv_arb_starve_ctr.sv
// Counts back-to-back data grants that bypassed a waiting fetch; raises
// force_if once the count reaches STARVE_LIMIT.
module riscv_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic dm_grant,
  input  logic if_grant,
  output logic force_if
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (if_grant) begin
      count <= '0;
    end else if (dm_grant) begin
      count <= if_req ? count + 4'd1 : 4'd0;
    end
  end

  assign force_if = if_req && (count == 4'(STARVE_LIMIT));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter between IF and MEM stages, data over fetch.
// Define ARB_STARVE_GUARD_EN to force a fetch after STARVE_LIMIT data grants.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ack,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_stall,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  input  logic [3:0]      dm_be,
  output logic            dm_ack,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  arb_state_e state;
  arb_owner_e owner;
  mem_req_t   mem_q;
  logic       force_if;
  logic       grant_dm;
  logic       grant_if;

  assign grant_dm = (state == ARB_IDLE) && dm_req && !force_if;
  assign grant_if = (state == ARB_IDLE) && if_req && !grant_dm;

`ifdef ARB_STARVE_GUARD_EN
  riscv_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .dm_grant (grant_dm),
    .if_grant (grant_if),
    .force_if (force_if)
  );
`else
  logic [3:0] unused_limit;
  assign unused_limit = 4'(STARVE_LIMIT);
  assign force_if     = 1'b0;
`endif

  // Each access walks IDLE -> BUSY -> RESP; acks are single-cycle pulses in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      owner    <= OWN_NONE;
      mem_q    <= '0;
      mem_req  <= 1'b0;
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_dm) begin
            owner       <= OWN_DM;
            mem_q.we    <= dm_we;
            mem_q.addr  <= dm_addr;
            mem_q.wdata <= dm_wdata;
            mem_q.be    <= dm_be;
            mem_req     <= 1'b1;
            state       <= ARB_BUSY;
          end else if (grant_if) begin
            owner   <= OWN_IF;
            mem_q   <= fetch_req(if_addr);
            mem_req <= 1'b1;
            state   <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= ARB_RESP;
            if (owner == OWN_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              dm_ack   <= 1'b1;
              dm_rdata <= mem_q.we ? '0 : mem_rdata;
            end
          end
        end
        ARB_RESP: begin
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          owner  <= OWN_NONE;
          state  <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign mem_we    = mem_q.we;
  assign mem_addr  = mem_q.addr;
  assign mem_wdata = mem_q.wdata;
  assign mem_be    = mem_q.be;

  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: transaction-level model plus
// directed scenarios with literal expectations.
module tb_riscv_mem_arbiter;
  import riscv_mem_arbiter_pkg::*;

  localparam int LIMIT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_be = '0;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  riscv_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who holds the memory, who is being acked.
  int          m_busy_who = 0;   // 0 none, 1 fetch, 2 data
  int          m_ack_who = 0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_dm_rdata = '0;
  int          m_starve = 0;
  bit          m_forced;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy_who = 0; m_ack_who = 0; m_starve = 0;
      m_if_rdata = '0; m_dm_rdata = '0;
    end else if (m_ack_who != 0) begin
      m_ack_who = 0;
    end else if (m_busy_who != 0) begin
      if (mem_ready) begin
        if (m_busy_who == 1) m_if_rdata = mem_rdata;
        else                 m_dm_rdata = m_we ? 32'h0 : mem_rdata;
        m_ack_who  = m_busy_who;
        m_busy_who = 0;
      end
    end else begin
`ifdef ARB_STARVE_GUARD_EN
      m_forced = if_req && (m_starve == LIMIT);
`else
      m_forced = 1'b0;
`endif
      if (dm_req && !m_forced) begin
        m_busy_who = 2;
        m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_be = dm_be;
        m_starve = if_req ? m_starve + 1 : 0;
      end else if (if_req) begin
        m_busy_who = 1;
        m_we = 1'b0; m_addr = if_addr; m_wdata = 32'h0; m_be = 4'hF;
        m_starve = 0;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("mem_req", 32'(mem_req), 32'(m_busy_who != 0));
    if (m_busy_who != 0) begin
      checkOutput("mem_addr", mem_addr, m_addr);
      checkOutput("mem_we", 32'(mem_we), 32'(m_we));
      checkOutput("mem_wdata", mem_wdata, m_wdata);
      checkOutput("mem_be", 32'(mem_be), 32'(m_be));
    end
    checkOutput("if_ack", 32'(if_ack), 32'(m_ack_who == 1));
    checkOutput("dm_ack", 32'(dm_ack), 32'(m_ack_who == 2));
    checkOutput("if_rdata", if_rdata, m_if_rdata);
    checkOutput("dm_rdata", dm_rdata, m_dm_rdata);
    checkOutput("if_stall", 32'(if_stall), 32'(if_req & (m_ack_who != 1)));
    checkOutput("dm_stall", 32'(dm_stall), 32'(dm_req & (m_ack_who != 2)));
  end

  int          lat, busy;
  bit          moved;
  logic [31:0] cap_addr, cap_wdata, cap_rdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  // One access from one port; records latency, busy cycles and what memory saw.
  task automatic applyStimulus(input bit is_dm, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [31:0] rdata, input int waits);
    bit done = 1'b0;
    @(posedge clk); #1;
    if (is_dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_be = be;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    mem_rdata = rdata;
    mem_ready = (waits == 0);
    lat = -1; busy = 0; moved = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_req) begin
        if (busy == 0) begin
          cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata; cap_be = mem_be;
        end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_be !== cap_be) begin
          moved = 1'b1;
        end
        busy++;
      end
      if (is_dm ? dm_ack : if_ack) begin
        lat = c;
        cap_rdata = is_dm ? dm_rdata : if_rdata;
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (!done) mem_ready = (waits == 0) || (c + 1 >= waits + 1);
    end
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
    checkOutput("ack_seen", 32'(done), 32'd1);
  endtask

  int dm_ack_c, if_ack_c, if_go_c, stall_n, n_grants;
  int order[6];
  int exp_order[6];
  bit prev_req, a_if, a_dm;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_if_ack", 32'(if_ack), 32'd0);
    checkOutput("rst_dm_ack", 32'(dm_ack), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;

    $display("[TB] fetch only");
    applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 32'h00000013, 0);
    checkOutput("fetch_lat", 32'(lat), 32'd2);
    checkOutput("fetch_addr", cap_addr, 32'h100);
    checkOutput("fetch_we", 32'(cap_we), 32'd0);
    checkOutput("fetch_be", 32'(cap_be), 32'hF);
    checkOutput("fetch_rdata", cap_rdata, 32'h00000013);

    $display("[TB] store");
    applyStimulus(1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011, 32'hFFFFFFFF, 0);
    checkOutput("store_lat", 32'(lat), 32'd2);
    checkOutput("store_busy", 32'(busy), 32'd1);
    checkOutput("store_addr", cap_addr, 32'h2004);
    checkOutput("store_wdata", cap_wdata, 32'hDEADBEEF);
    checkOutput("store_be", 32'(cap_be), 32'h3);
    checkOutput("store_we", 32'(cap_we), 32'd1);
    checkOutput("store_rdata", cap_rdata, 32'h0);

    $display("[TB] load with wait states");
    applyStimulus(1'b1, 1'b0, 32'h3008, 32'h0, 4'hF, 32'hCAFEF00D, 3);
    checkOutput("wait_lat", 32'(lat), 32'd5);
    checkOutput("wait_busy", 32'(busy), 32'd4);
    checkOutput("wait_stable", 32'(moved), 32'd0);
    checkOutput("wait_rdata", cap_rdata, 32'hCAFEF00D);

    $display("[TB] simultaneous requests");
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h400;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h800; dm_be = 4'hF;
    mem_ready = 1'b1; mem_rdata = 32'h00001234;
    dm_ack_c = -1; if_ack_c = -1; if_go_c = -1; stall_n = 0;
    for (int c = 0; c < 20 && if_ack_c < 0; c++) begin
      @(negedge clk);
      if (if_stall) stall_n++;
      if (mem_req && mem_addr == 32'h400 && if_go_c < 0) if_go_c = c;
      if (dm_ack) dm_ack_c = c;
      if (if_ack) if_ack_c = c;
      @(posedge clk); #1;
      if (dm_ack_c >= 0) dm_req = 1'b0;
      if (if_ack_c >= 0) if_req = 1'b0;
    end
    if_req = 1'b0; dm_req = 1'b0;
    checkOutput("sim_dm_ack_cycle", 32'(dm_ack_c), 32'd2);
    checkOutput("sim_if_grant_cycle", 32'(if_go_c), 32'd4);
    checkOutput("sim_if_ack_cycle", 32'(if_ack_c), 32'd5);
    checkOutput("sim_if_stall_cycles", 32'(stall_n), 32'd5);

    $display("[TB] continuous contention");
`ifdef ARB_STARVE_GUARD_EN
    exp_order = '{2, 2, 1, 2, 2, 1};
`else
    exp_order = '{2, 2, 2, 2, 2, 2};
`endif
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h400;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h800;
    mem_ready = 1'b1;
    n_grants = 0; prev_req = 1'b0;
    for (int c = 0; c < 60 && n_grants < 6; c++) begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        order[n_grants] = (mem_addr == 32'h400) ? 1 : 2;
        n_grants++;
      end
      prev_req = mem_req;
    end
    for (int c = 0; c < 40 && (if_req || dm_req); c++) begin
      @(negedge clk);
      a_if = if_ack; a_dm = dm_ack;
      @(posedge clk); #1;
      if (a_if) if_req = 1'b0;
      if (a_dm) dm_req = 1'b0;
    end
    checkOutput("cont_grants", 32'(n_grants), 32'd6);
    checkOutput("cont_drained", 32'(if_req | dm_req), 32'd0);
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) checkOutput($sformatf("grant_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));

    $display("[TB] reset during busy");
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h300; mem_ready = 1'b0;
    @(posedge clk); #2;
    checkOutput("pre_rst_mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("midrst_mem_addr", mem_addr, 32'd0);
    checkOutput("midrst_if_ack", 32'(if_ack), 32'd0);
    checkOutput("midrst_if_rdata", if_rdata, 32'd0);
    checkOutput("midrst_dm_rdata", dm_rdata, 32'd0);
    checkOutput("midrst_mem_be", 32'(mem_be), 32'd0);
    if_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 32'h00100093, 0);
    checkOutput("post_rst_lat", 32'(lat), 32'd2);
    checkOutput("post_rst_addr", cap_addr, 32'h104);
    checkOutput("post_rst_rdata", cap_rdata, 32'h00100093);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
